// File: rtl/led_display_seq.sv
// Registered LED mode sequencer for the tug-of-war board: static modes plus blink, chase and win-flash.
// Define LED_PWM_EN to add the duty[3:0] input and PWM dimming inside the output register.
module led_display_seq #(
    parameter int                  NUM_LEDS    = 7,
    parameter logic [NUM_LEDS-1:0] PATTERN     = 7'b1001101,
    parameter logic [NUM_LEDS-1:0] ALT_PATTERN = 7'b1010101,
    parameter int                  TICK_DIV    = 25000000,
    parameter int                  FLASH_COUNT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          mode,
    input  logic [NUM_LEDS-1:0] score,
`ifdef LED_PWM_EN
    input  logic [3:0]          duty,
`endif
    output logic [NUM_LEDS-1:0] leds_out,
    output logic                tick,
    output logic                win_done
);

    localparam int PS_W = $clog2(TICK_DIV);
    localparam int CP_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int FC_W = ($clog2(FLASH_COUNT + 1) > 1) ? $clog2(FLASH_COUNT + 1) : 1;

    localparam logic [PS_W-1:0] PS_LAST   = PS_W'(TICK_DIV - 1);
    localparam logic [CP_W-1:0] CP_LAST   = CP_W'(NUM_LEDS - 1);
    localparam logic [FC_W-1:0] FC_TARGET = FC_W'(FLASH_COUNT);

    localparam logic [2:0] MODE_OFF     = 3'd0;
    localparam logic [2:0] MODE_ALL_ON  = 3'd1;
    localparam logic [2:0] MODE_SCORE   = 3'd2;
    localparam logic [2:0] MODE_PATTERN = 3'd3;
    localparam logic [2:0] MODE_BLINK   = 3'd4;
    localparam logic [2:0] MODE_CHASE   = 3'd5;
    localparam logic [2:0] MODE_WIN     = 3'd6;

    localparam logic [1:0] FLASH_ON  = 2'd0;
    localparam logic [1:0] FLASH_OFF = 2'd1;
    localparam logic [1:0] HOLD      = 2'd2;

    logic [PS_W-1:0]     prescaler, prescaler_nxt;
    logic                phase, phase_nxt;
    logic [CP_W-1:0]     chase_pos, chase_pos_nxt;
    logic [FC_W-1:0]     flash_cnt, flash_cnt_nxt;
    logic [1:0]          win_state, win_state_nxt;
    logic [2:0]          mode_q;
    logic                mode_change;
    logic                win_done_nxt;
    logic [NUM_LEDS-1:0] chase_onehot;
    logic [NUM_LEDS-1:0] disp_pattern;
    logic [NUM_LEDS-1:0] led_gate;

    assign mode_change   = (mode != mode_q);
    assign prescaler_nxt = (prescaler == PS_LAST) ? '0 : prescaler + 1'b1;

    // Animation state advances on the registered tick; a mode change restarts every animation.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path can infer a latch.
        phase_nxt     = phase;
        chase_pos_nxt = chase_pos;
        flash_cnt_nxt = flash_cnt;
        win_state_nxt = win_state;
        if (mode_change) begin
            phase_nxt     = 1'b0;
            chase_pos_nxt = '0;
            flash_cnt_nxt = '0;
            win_state_nxt = FLASH_ON;
        end else if (tick) begin
            phase_nxt = ~phase;
            if (mode == MODE_CHASE) begin
                chase_pos_nxt = (chase_pos == CP_LAST) ? '0 : chase_pos + 1'b1;
            end
            if (mode == MODE_WIN) begin
                case (win_state)
                    FLASH_ON:  win_state_nxt = FLASH_OFF;
                    FLASH_OFF: begin
                        flash_cnt_nxt = flash_cnt + 1'b1;
                        win_state_nxt = (flash_cnt_nxt == FC_TARGET) ? HOLD : FLASH_ON;
                    end
                    HOLD:      win_state_nxt = HOLD;
                    default:   win_state_nxt = FLASH_ON;
                endcase
            end
        end
    end

    // Display pattern from the incoming mode and the state in effect before the edge.
    always_comb begin
        chase_onehot            = '0;
        chase_onehot[chase_pos] = 1'b1;
        case (mode)
            MODE_OFF:     disp_pattern = '0;
            MODE_ALL_ON:  disp_pattern = '1;
            MODE_SCORE:   disp_pattern = score;
            MODE_PATTERN: disp_pattern = PATTERN;
            MODE_BLINK:   disp_pattern = phase ? '0 : score;
            MODE_CHASE:   disp_pattern = chase_onehot;
            MODE_WIN: begin
                case (win_state)
                    FLASH_ON:  disp_pattern = '1;
                    HOLD:      disp_pattern = score;
                    default:   disp_pattern = '0;
                endcase
            end
            default:      disp_pattern = ALT_PATTERN;
        endcase
    end

    assign win_done_nxt = (mode == MODE_WIN) && !mode_change && (win_state == HOLD);

`ifdef LED_PWM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + 4'd1;
    end

    assign led_gate = {NUM_LEDS{pwm_cnt < duty}};
`else
    assign led_gate = '1;
`endif

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            prescaler <= '0;
            tick      <= 1'b0;
            phase     <= 1'b0;
            chase_pos <= '0;
            flash_cnt <= '0;
            win_state <= FLASH_ON;
            mode_q    <= '0;
            leds_out  <= '0;
            win_done  <= 1'b0;
        end else begin
            prescaler <= prescaler_nxt;
            tick      <= (prescaler_nxt == PS_LAST);
            phase     <= phase_nxt;
            chase_pos <= chase_pos_nxt;
            flash_cnt <= flash_cnt_nxt;
            win_state <= win_state_nxt;
            mode_q    <= mode;
            leds_out  <= disp_pattern & led_gate;
            win_done  <= win_done_nxt;
        end
    end

endmodule
